// File: rtl/hgc_vram_arbiter.sv
`timescale 1ns/1ps
// VRAM arbiter: the video fetch path owns the SRAM whenever vram_read is high.
// Host reads and writes run as 3-clock operations that start only in a sequencer window.
module hgc_vram_arbiter (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        isa_op_enable,
  input  logic        vram_read,
  input  logic [15:0] vid_addr,
  input  logic        host_req,
  input  logic        host_we,
  input  logic [15:0] host_addr,
  input  logic [7:0]  host_wdata,
  output logic [7:0]  host_rdata,
  output logic        host_rdy,
  output logic [15:0] ram_a,
  output logic [7:0]  ram_d_out,
  output logic        ram_d_oe,
  input  logic [7:0]  ram_d_in,
  output logic        ram_we_n,
  output logic        ram_oe_n,
  output logic [7:0]  collisions,
  output logic [2:0]  fsm_state
);

  // Host handshake: host_req is a level held by the host until it sees host_rdy=1
  // after acceptance. host_rdy is 1 only in IDLE and DONE. A request still held in
  // DONE is not relaunched; DONE returns to IDLE once host_req is low.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_WIN = 3'd1,
    OP1      = 3'd2,
    OP2      = 3'd3,
    OP3      = 3'd4,
    DONE     = 3'd5
  } state_t;

  state_t      state;
  logic        we_q;
  logic [15:0] addr_q;
  logic [7:0]  wdata_q;
  logic        window;
  logic        in_op;
  logic        host_owns;

  assign window    = isa_op_enable && !vram_read;
  assign in_op     = (state == OP1) || (state == OP2) || (state == OP3);
  assign host_owns = in_op && !vram_read;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      we_q       <= 1'b0;
      addr_q     <= 16'h0000;
      wdata_q    <= 8'h00;
      host_rdata <= 8'h00;
      collisions <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (host_req) begin
            we_q    <= host_we;
            addr_q  <= host_addr;
            wdata_q <= host_wdata;
            state   <= window ? OP1 : WAIT_WIN;
          end
        end
        WAIT_WIN: begin
          if (window) state <= OP1;
        end
        OP1, OP2, OP3: begin
          if (vram_read) begin
            // Video stole this cycle: abandon the attempt and retry all 3 clocks.
            state <= WAIT_WIN;
            if (collisions != 8'hFF) collisions <= collisions + 8'd1;
          end else if (state == OP1) begin
            state <= OP2;
          end else if (state == OP2) begin
            state <= OP3;
          end else begin
            state <= DONE;
            if (!we_q) host_rdata <= ram_d_in;
          end
        end
        DONE: begin
          if (!host_req) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign host_rdy  = (state == IDLE) || (state == DONE);
  assign ram_a     = host_owns ? addr_q : vid_addr;
  assign ram_d_out = wdata_q;
  assign ram_d_oe  = host_owns && we_q;
  assign ram_we_n  = !(host_owns && we_q && (state == OP2));
  // Reset forces the output enable off even if the sequencer is fetching.
  assign ram_oe_n  = !reset_n || (host_owns ? we_q : !vram_read);
  assign fsm_state = state;

endmodule

// File: tb/tb_hgc_vram_arbiter.sv
`timescale 1ns/1ps
// Bench for hgc_vram_arbiter: directed scenarios plus randomized host/video traffic,
// checked every cycle against a transaction-level model and a behavioural SRAM.
module tb_hgc_vram_arbiter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic        isa_op_enable, vram_read, host_req, host_we;
  logic [15:0] vid_addr, host_addr, ram_a;
  logic [7:0]  host_wdata, host_rdata, ram_d_out, ram_d_in, collisions;
  logic        host_rdy, ram_d_oe, ram_we_n, ram_oe_n;
  logic [2:0]  fsm_state;

  hgc_vram_arbiter dut (
    .clk(clk), .reset_n(reset_n), .isa_op_enable(isa_op_enable), .vram_read(vram_read),
    .vid_addr(vid_addr), .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_rdata(host_rdata), .host_rdy(host_rdy), .ram_a(ram_a),
    .ram_d_out(ram_d_out), .ram_d_oe(ram_d_oe), .ram_d_in(ram_d_in), .ram_we_n(ram_we_n),
    .ram_oe_n(ram_oe_n), .collisions(collisions), .fsm_state(fsm_state)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [7:0] init_val(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hC2;
  endfunction

  // ---------------- behavioural SRAM ----------------
  logic [7:0] sram    [0:65535];
  bit         sram_wr [0:65535];
  int         we_count = 0;

  always_comb ram_d_in = sram_wr[ram_a] ? sram[ram_a] : init_val(ram_a);

  always @(posedge clk) begin
    if (!ram_we_n) begin
      sram[ram_a]    <= ram_d_out;
      sram_wr[ram_a] <= 1'b1;
      we_count++;
    end
  end

  function automatic logic [7:0] sram_peek(input logic [15:0] a);
    return sram_wr[a] ? sram[a] : init_val(a);
  endfunction

  // ---------------- transaction model ----------------
  // m_cnt = -1 when no attempt is running, else clean cycles already spent (0..2).
  bit          m_pending, m_done, m_we;
  int          m_cnt = -1;
  int          m_coll;
  logic [15:0] m_addr;
  logic [7:0]  m_wdata, m_rdata;
  logic [7:0]  m_mem [0:65535];
  bit          m_wr  [0:65535];
  logic [7:0]  exp_q[$];

  always @(posedge clk) begin
    if (!reset_n) begin
      m_pending = 0; m_done = 0; m_we = 0; m_cnt = -1; m_coll = 0;
      m_addr = '0; m_wdata = '0; m_rdata = '0;
      exp_q.delete();
    end else if (m_pending) begin
      if (m_cnt >= 0) begin
        if (vram_read) begin
          m_cnt = -1;
          if (m_coll < 255) m_coll++;
        end else if (m_cnt == 2) begin
          m_cnt = -1; m_pending = 0; m_done = 1;
          if (m_we) begin
            m_mem[m_addr] = m_wdata; m_wr[m_addr] = 1;
          end else begin
            m_rdata = m_wr[m_addr] ? m_mem[m_addr] : init_val(m_addr);
            exp_q.push_back(m_rdata);
          end
        end else m_cnt++;
      end else if (isa_op_enable && !vram_read) m_cnt = 0;
    end else if (m_done) begin
      if (!host_req) m_done = 0;
    end else if (host_req) begin
      m_pending = 1; m_we = host_we; m_addr = host_addr; m_wdata = host_wdata;
      m_cnt = (isa_op_enable && !vram_read) ? 0 : -1;
    end
  end

  // ---------------- per-cycle compare + read scoreboard ----------------
  logic [15:0] e_a;
  logic        e_own, e_doe, e_wen, e_oen, e_rdy, prev_rdy = 1'b1;
  logic [2:0]  e_state;

  always @(negedge clk) begin
    if (!reset_n) begin
      check("rst_rdy", host_rdy, 1);   check("rst_rdata", host_rdata, 0);
      check("rst_we_n", ram_we_n, 1);  check("rst_oe_n", ram_oe_n, 1);
      check("rst_d_oe", ram_d_oe, 0);  check("rst_d_out", ram_d_out, 0);
      check("rst_ram_a", ram_a, vid_addr); check("rst_coll", collisions, 0);
      check("rst_state", fsm_state, 0);
    end else begin
      e_own   = m_pending && (m_cnt >= 0) && !vram_read;
      e_a     = e_own ? m_addr : vid_addr;
      e_doe   = e_own && m_we;
      e_wen   = !(e_doe && m_cnt == 1);
      e_oen   = e_own ? m_we : !vram_read;
      e_rdy   = !m_pending;
      e_state = !m_pending ? (m_done ? 3'd5 : 3'd0) : (m_cnt < 0 ? 3'd1 : 3'(2 + m_cnt));
      check("ram_a", ram_a, e_a);         check("ram_d_oe", ram_d_oe, e_doe);
      check("ram_we_n", ram_we_n, e_wen); check("ram_oe_n", ram_oe_n, e_oen);
      check("host_rdy", host_rdy, e_rdy); check("host_rdata", host_rdata, m_rdata);
      check("collisions", collisions, m_coll); check("fsm_state", fsm_state, e_state);
      if (e_doe) check("ram_d_out", ram_d_out, m_wdata);
      if (host_rdy && !prev_rdy && !m_we) begin
        if (exp_q.size() == 0) check("rd_queue_nonempty", exp_q.size(), 1);
        else check("rd_data", host_rdata, exp_q.pop_front());
      end
    end
    prev_rdy = host_rdy;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_rdy(input string name);
    int n = 0;
    while (!host_rdy && n < 100) begin tick(); n++; end
    check(name, host_rdy, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int wc0, hs, gap, age;
    reset_n = 0; isa_op_enable = 0; vram_read = 1; vid_addr = 16'hBEEF;
    host_req = 0; host_we = 0; host_addr = 0; host_wdata = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_oe_n_forced", ram_oe_n, 1);
    check("reset_ram_a", ram_a, 16'hBEEF);
    vram_read = 0;
    reset_n = 1;
    tick();

    // Write 0x5A to 0x1234 inside an open window.
    isa_op_enable = 1; host_req = 1; host_we = 1; host_addr = 16'h1234; host_wdata = 8'h5A;
    #1 check("s1_idle_ram_a", ram_a, 16'hBEEF);
    tick(); check("s1_op1_a", ram_a, 16'h1234); check("s1_op1_we_n", ram_we_n, 1); check("s1_op1_rdy", host_rdy, 0);
    tick(); check("s1_op2_a", ram_a, 16'h1234); check("s1_op2_we_n", ram_we_n, 0);
    tick(); check("s1_op3_a", ram_a, 16'h1234); check("s1_op3_we_n", ram_we_n, 1);
    tick(); check("s1_done_rdy", host_rdy, 1);
    host_req = 0; tick();
    check("s1_sram", sram_peek(16'h1234), 8'h5A);

    // Read 0x0100 accepted outside a window; host fields change while waiting.
    isa_op_enable = 0; host_req = 1; host_we = 0; host_addr = 16'h0100;
    tick(); check("s2_wait_state", fsm_state, 1); check("s2_wait_rdy", host_rdy, 0);
    host_addr = 16'hFFFF; host_we = 1;
    repeat (4) tick();
    check("s2_still_wait", fsm_state, 1);
    isa_op_enable = 1;
    tick(); check("s2_op1_a", ram_a, 16'h0100); check("s2_op1_oe_n", ram_oe_n, 0);
    wait_rdy("s2_rdy");
    check("s2_rdata", host_rdata, 8'hC3);
    host_req = 0; tick();

    // vram_read pulse in OP2 of a write: no strobe, retry, one collision.
    wc0 = we_count;
    host_req = 1; host_we = 1; host_addr = 16'h0042; host_wdata = 8'hA5;
    tick(); tick();
    vram_read = 1; vid_addr = 16'h2222;
    #1;
    check("s3_coll_we_n", ram_we_n, 1); check("s3_coll_a", ram_a, 16'h2222);
    check("s3_coll_oe_n", ram_oe_n, 0); check("s3_coll_d_oe", ram_d_oe, 0);
    tick(); vram_read = 0;
    check("s3_wait_state", fsm_state, 1);
    check("s3_no_strobe", we_count - wc0, 0);
    tick(); wait_rdy("s3_rdy");
    check("s3_collisions", collisions, 1);
    check("s3_one_strobe", we_count - wc0, 1);
    check("s3_sram", sram_peek(16'h0042), 8'hA5);
    host_req = 0; tick();

    // 256 forced collisions saturate the counter.
    host_req = 1; host_we = 1; host_addr = 16'h0055; host_wdata = 8'h11;
    tick();
    for (int i = 0; i < 256; i++) begin
      vram_read = 1; tick();
      vram_read = 0; tick();
    end
    wait_rdy("s4_rdy");
    check("s4_saturated", collisions, 8'hFF);
    host_req = 0; tick();

    // Request held 20 clocks after DONE: exactly one strobe.
    wc0 = we_count;
    host_req = 1; host_we = 1; host_addr = 16'h0066; host_wdata = 8'h77;
    tick(); wait_rdy("s5_rdy");
    repeat (20) tick();
    check("s5_held_state", fsm_state, 5); check("s5_held_rdy", host_rdy, 1);
    check("s5_one_strobe", we_count - wc0, 1);
    host_req = 0; tick();
    check("s5_idle", fsm_state, 0);

    // Reset asserted in OP2 of a write.
    reset_n = 0; tick(); reset_n = 1; tick();
    check("s6_coll_cleared", collisions, 0);
    host_req = 1; host_we = 1; host_addr = 16'h0777; host_wdata = 8'h99;
    tick(); tick();
    check("s6_op2_we_n", ram_we_n, 0);
    reset_n = 0;
    #1;
    check("s6_rst_we_n", ram_we_n, 1); check("s6_rst_rdy", host_rdy, 1);
    check("s6_rst_coll", collisions, 0); check("s6_rst_state", fsm_state, 0);
    host_req = 0; tick(); reset_n = 1; tick();
    check("s6_sram_untouched", sram_peek(16'h0777), init_val(16'h0777));

    // Randomized traffic.
    hs = 0; gap = 0; age = 0;
    for (int c = 0; c < 3000; c++) begin
      isa_op_enable = ($urandom_range(0, 2) != 0);
      vram_read     = ($urandom_range(0, 4) == 0);
      vid_addr      = 16'($urandom);
      if (hs == 0) begin
        if (gap > 0) gap--;
        else begin
          host_req = 1; host_we = 1'($urandom_range(0, 1));
          host_addr = 16'($urandom_range(0, 31)); host_wdata = 8'($urandom);
          hs = 1; age = 0;
        end
      end else if (hs == 1) begin
        age++;
        if (age > 1 && host_rdy) begin
          host_req = 0; hs = 0; gap = $urandom_range(0, 3);
        end else if (age > 1) begin
          host_addr = 16'($urandom); host_wdata = 8'($urandom); host_we = 1'($urandom);
          if ($urandom_range(0, 60) == 0) begin host_req = 0; hs = 2; end
        end
      end else if (host_rdy) begin
        hs = 0; gap = 2;
      end
      tick();
    end
    isa_op_enable = 1; vram_read = 0;
    repeat (10) tick();
    host_req = 0;
    repeat (3) tick();
    check("final_queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/hgc_vram_arbiter.md
HGC_VRAM_ARBITER -- requirements
Module: hgc_vram_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset. The ports are `clk` (clock) and `reset_n` (reset).
REQ-002 clk  in  1  pixel/sequencer clock; all state changes on its rising edge.
REQ-003 reset_n  in  1  asynchronous active-low reset.
REQ-004 isa_op_enable  in  1  sequencer window in which a host VRAM operation may be launched.
REQ-005 vram_read  in  1  sequencer video-fetch strobe; video owns VRAM whenever high.
REQ-006 vid_addr  in  16  video fetch address.
REQ-007 host_req  in  1  synchronized host memory request, level; held until host_rdy seen high.
REQ-008 host_we  in  1  1 = write, 0 = read; sampled with host_addr/host_wdata at acceptance.
REQ-009 host_addr  in  16  host VRAM byte address.
REQ-010 host_wdata  in  8  host write data.
REQ-011 host_rdata  out  8  read data, valid while host_rdy=1 after a read.
REQ-012 host_rdy  out  1  bus-ready; 0 = insert wait states.
REQ-013 ram_a  out  16  SRAM address.
REQ-014 ram_d_out  out  8  SRAM write data.
REQ-015 ram_d_oe  out  1  SRAM data-bus drive enable.
REQ-016 ram_d_in  in  8  SRAM read data.
REQ-017 ram_we_n  out  1  SRAM write strobe, active low.
REQ-018 ram_oe_n  out  1  SRAM output enable, active low.
REQ-019 collisions  out  8  saturating count of host operations aborted by video.

Function
REQ-020 The FSM SHALL have the states IDLE, WAIT_WIN, OP1, OP2, OP3, DONE.
REQ-021 In IDLE, host_req=1 SHALL latch host_we/addr/wdata, drop host_rdy to 0, and go to OP1 if isa_op_enable=1 and vram_read=0 in that cycle, else to WAIT_WIN.
REQ-022 WAIT_WIN SHALL go to OP1 on the first cycle with isa_op_enable=1 and vram_read=0; otherwise it stays.
REQ-023 OP1->OP2->OP3->DONE SHALL advance one state per clock, so a host operation occupies exactly 3 clocks.
REQ-024 ram_a SHALL equal the latched host address in OP1-OP3 with vram_read=0, and vid_addr in every other cycle.
REQ-025 For a write: ram_d_oe=1 and ram_d_out=latched data in OP1-OP3; ram_we_n=0 only in OP2; ram_oe_n=1 throughout.
REQ-026 For a read: ram_oe_n=0 in OP1-OP3; host_rdata SHALL capture ram_d_in on the clock edge leaving OP3.
REQ-027 Outside host ops, ram_oe_n SHALL be the inverse of vram_read; ram_we_n=1 and ram_d_oe=0.
REQ-028 vram_read=1 in OP1, OP2 or OP3 is a collision, handled as follows:
 - The video side wins combinationally that cycle: ram_a=vid_addr, ram_we_n=1, ram_d_oe=0, ram_oe_n=0.
 - The FSM goes to WAIT_WIN, and the whole 3-cycle op is retried.
 - collisions increments, saturating at 255.
REQ-029 In DONE, host_rdy SHALL be 1; the FSM stays until host_req=0, then goes to IDLE.
REQ-030 In IDLE, host_rdy SHALL be 1 while host_req=0.
REQ-031 Each host_req assertion SHALL launch exactly one operation; a request held high in DONE SHALL NOT relaunch.
REQ-032 Changes on host_we/addr/wdata after acceptance SHALL be ignored until the next IDLE acceptance.
REQ-033 If host_req drops in WAIT_WIN or OP1-OP3 (a protocol violation), the op SHALL still complete, and DONE then exits to IDLE next cycle.
REQ-034 Worst-case latency from acceptance to host_rdy=1 SHALL be bounded by one sequencer period (32 clocks in graphics mode, 18 in text mode) plus 4 clocks, absent collisions.

Reset
REQ-035 While reset_n=0, outputs SHALL be as follows:
 - FSM in IDLE.
 - host_rdy=1, host_rdata=0x00.
 - ram_we_n=1, ram_oe_n=1, ram_d_oe=0, ram_d_out=0x00.
 - ram_a=vid_addr.
 - collisions=0.
 - latched host fields=0.
REQ-036 Reset asserted mid-operation SHALL abort it immediately with no write strobe completing, and SHALL NOT increment collisions.
REQ-037 After reset_n deasserts, the first accept SHALL occur no earlier than the first rising clk edge.

Verification
REQ-038 The bench SHALL cover the following directed scenarios:
 - Write 0x5A to 0x1234 with isa_op_enable=1 -> ram_a=0x1234 for 3 clocks; ram_we_n low only in the middle clock; host_rdy=1 on the 4th clock after accept.
 - Read of 0x0100 with ram_d_in=0xC3, accepted while isa_op_enable=0 -> stays WAIT_WIN until enable=1; host_rdata=0xC3 once host_rdy=1.
 - vram_read pulsed during OP2 of a write -> ram_we_n never low in that attempt; retried on the next window; collisions=1.
 - 256 forced collisions -> collisions=255.
 - host_req held high 20 clocks after DONE -> exactly one SRAM write strobe.
 - reset_n low during OP2 -> ram_we_n=1, host_rdy=1, collisions unchanged at 0.
